// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive and transmit paths.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Two-of-three vote used to reject single-sample noise around mid-bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// The reset value is a parameter so an idle-high serial line does not
// look like a start bit while reset is released.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: majority-voted mid-bit sampling, LSB first,
// registered byte output with single-cycle valid / framing-error strobes.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | line idle, waiting for rxs low
// START     | validating the start bit; a high vote at mid-bit aborts
// DATA      | shifting in 8 data bits, LSB first
// STOP      | voting the stop bit; acts at mid-bit to catch back-to-back frames
// WAIT_IDLE | stop bit was low (break/noise); hold until the line goes high
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_i,
    output logic [UART_DATA_W-1:0] data_o,
    output logic                   valid_o,
    output logic                   frame_err_o,
    output logic                   busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(HALF + 1);

    logic rxs;

    rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] shreg_q, shreg_d;
    logic                   samp0_q, samp0_d;
    logic                   samp1_q, samp1_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q, busy_d;

    logic at_dec;
    logic at_last;
    logic bit_dec;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx_i),
        .q_o   (rxs)
    );

    // The third sample is the live rxs, so the vote resolves at HALF+1.
    assign at_dec  = (cnt_q == CNT_DEC);
    assign at_last = (cnt_q == CNT_LAST);
    assign bit_dec = maj3(samp0_q, samp1_q, rxs);

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            samp0_q <= 1'b1;
            samp1_q <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            samp0_q <= samp0_d;
            samp1_q <= samp1_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, bit timing, sampling and shift register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        samp0_d = samp0_q;
        samp1_d = samp1_q;

        if (cnt_q == CNT_S0) samp0_d = rxs;
        if (cnt_q == CNT_S1) samp1_d = rxs;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // The detecting cycle is bit-cycle 0, so START begins at 1.
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = CNT_ONE;
                end
            end
            START: begin
                cnt_d = cnt_q + CNT_ONE;
                if (at_dec && bit_dec) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (at_last) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            DATA: begin
                cnt_d = cnt_q + CNT_ONE;
                if (at_dec) shreg_d = {bit_dec, shreg_q[UART_DATA_W-1:1]};
                if (at_last) begin
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = cnt_q + CNT_ONE;
                if (at_dec) begin
                    cnt_d   = '0;
                    state_d = bit_dec ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output strobes and byte latch, registered next cycle.
    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        busy_d  = (state_q != IDLE);
        if ((state_q == STOP) && at_dec) begin
            if (bit_dec) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ferr_d = 1'b1;
            end
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit.
// Line is driven and outputs are sampled on the falling clock edge.
module tb_uart_rx_byte;

    localparam int CPB = 16;
    // rx_i drive -> valid_o visible: 2 sync + (9*16 + 8 + 1) + 1 register.
    localparam int LAT = 156;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         vcount = 0;
    int         ecount = 0;
    int         both_cnt = 0;
    int         long_cnt = 0;
    int         busy_cnt = 0;
    int         last_vcyc = 0;
    int         fall_cyc = 0;
    logic [7:0] last_data = 8'h00;
    logic       prev_valid = 1'b0;
    logic       prev_err = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         per;
        int         gap;
        logic       chk_lat;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o) begin
            vcount++;
            last_data = data_o;
            last_vcyc = cyc;
        end
        if (frame_err_o) ecount++;
        if (valid_o && frame_err_o) both_cnt++;
        if ((valid_o && prev_valid) || (frame_err_o && prev_err)) long_cnt++;
        if (busy_o) busy_cnt++;
        prev_valid = valid_o;
        prev_err   = frame_err_o;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // One 10-bit frame. gbit/goff invert one cycle of frame bit gbit;
    // rbit pulses reset in frame bit rbit, after which the sender gives up
    // on the frame and leaves the line idle.
    task automatic send(input logic [7:0] b, input int per, input logic stop_v,
                        input int gbit, input int goff, input int rbit);
        logic [9:0] fr;
        logic       aborted;
        fr       = {stop_v, b, 1'b0};
        aborted  = 1'b0;
        fall_cyc = cyc;
        for (int j = 0; j < 10; j++) begin
            for (int o = 0; o < per; o++) begin
                if (j == rbit && o == 4) aborted = 1'b1;
                rst_n = !(j == rbit && o == 4);
                if (aborted)
                    rx_i = 1'b1;
                else
                    rx_i = (j == gbit && o == goff) ? ~fr[j] : fr[j];
                @(negedge clk);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int v0;
        int e0;
        int b0;

        vecs[0] = '{8'hA5, 16, 20, 1'b1, 8'hA5};
        vecs[1] = '{8'h00, 16,  0, 1'b1, 8'h00};
        vecs[2] = '{8'hFF, 16,  0, 1'b1, 8'hFF};
        vecs[3] = '{8'h5A, 16, 20, 1'b1, 8'h5A};
        vecs[4] = '{8'hC3, 17, 20, 1'b0, 8'hC3};
        vecs[5] = '{8'hC3, 15, 20, 1'b0, 8'hC3};

        rst_n = 1'b0;
        rx_i  = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("reset data_o", data_o, 8'h00);
        chk("reset valid_o", valid_o, 0);
        chk("reset frame_err_o", frame_err_o, 0);
        chk("reset busy_o", busy_o, 0);
        rst_n = 1'b1;
        idle(10);

        for (int i = 0; i < 6; i++) begin
            v0 = vcount;
            e0 = ecount;
            send(vecs[i].data, vecs[i].per, 1'b1, -1, 0, -1);
            idle(vecs[i].gap);
            #1;
            chk($sformatf("vec%0d valid count", i), vcount - v0, 1);
            chk($sformatf("vec%0d data", i), last_data, vecs[i].exp_data);
            chk($sformatf("vec%0d frame_err count", i), ecount - e0, 0);
            if (vecs[i].chk_lat)
                chk($sformatf("vec%0d latency", i), last_vcyc - fall_cyc, LAT);
        end

        // 4-cycle low pulse: START for 9 cycles, then back to IDLE silently.
        v0 = vcount;
        e0 = ecount;
        b0 = busy_cnt;
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        #1;
        chk("glitch busy cycles", busy_cnt - b0, 9);
        chk("glitch busy_o after", busy_o, 0);
        chk("glitch valid count", vcount - v0, 0);
        chk("glitch frame_err count", ecount - e0, 0);

        // Inverted mid-sample of data bit 3 is outvoted.
        v0 = vcount;
        send(8'h0F, CPB, 1'b1, 4, 8, -1);
        idle(20);
        #1;
        chk("vote valid count", vcount - v0, 1);
        chk("vote data", last_data, 8'h0F);

        // Low stop bit followed by a 40-cycle break.
        v0 = vcount;
        e0 = ecount;
        send(8'h3C, CPB, 1'b0, -1, 0, -1);
        rx_i = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("ferr pulse count", ecount - e0, 1);
        chk("ferr valid count", vcount - v0, 0);
        chk("ferr data_o held", data_o, 8'h0F);
        chk("ferr busy during break", busy_o, 1);
        idle(20);
        #1;
        chk("ferr busy after break", busy_o, 0);
        chk("ferr no byte from break", vcount - v0, 0);
        send(8'h81, CPB, 1'b1, -1, 0, -1);
        idle(20);
        #1;
        chk("after ferr valid count", vcount - v0, 1);
        chk("after ferr data", last_data, 8'h81);
        chk("after ferr err count", ecount - e0, 1);

        // Reset during data bit 5 (frame bit 6) discards the byte.
        v0 = vcount;
        e0 = ecount;
        send(8'h77, CPB, 1'b1, -1, 0, 6);
        idle(20);
        #1;
        chk("rst mid valid count", vcount - v0, 0);
        chk("rst mid err count", ecount - e0, 0);
        chk("rst mid data_o", data_o, 8'h00);
        chk("rst mid busy_o", busy_o, 0);
        send(8'h12, CPB, 1'b1, -1, 0, -1);
        idle(20);
        #1;
        chk("after rst valid count", vcount - v0, 1);
        chk("after rst data", last_data, 8'h12);
        chk("after rst latency", last_vcyc - fall_cyc, LAT);

        chk("valid and frame_err together", both_cnt, 0);
        chk("strobe held over one cycle", long_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
